pipeline_ctrl: RTL and testbench

- Central hazard and redirect sequencer for the 5-stage core (IF, DEC, EXE, MEM, WB).
- Collects redirect and stall requests from the branch unit (flush, hold, branch, PC target) and ready signals from instruction and data memory.
- Drives the PC load mux, the per-stage register enables and bubble (NOP-insert) controls.
- Keeps saturating performance counters for stall cycles and flushes.

---
 rtl/pipeline_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard and redirect sequencer for the 5-stage core: PC load mux, stage enables,
// bubble inserts and saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             flushReq,
  input  logic             branchReq,
  input  logic             holdReq,
  input  logic [31:0]      PCtarget,
  input  logic             imemReady,
  input  logic             dmemReady,
  input  logic             perfClear,
  output logic             pcLoad,
  output logic [31:0]      pcNext,
  output logic             enIF,
  output logic             enDEC,
  output logic             enEXE,
  output logic             enMEM,
  output logic             bubbleDEC,
  output logic             bubbleEXE,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RUN,
    ST_LOAD_STALL,
    ST_REFILL,
    ST_MEM_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_pc_load;
  logic [31:0]      w_pc_next;
  logic             w_en_if;
  logic             w_en_dec;
  logic             w_en_exe;
  logic             w_en_mem;
  logic             w_bub_dec;
  logic             w_bub_exe;
  logic             w_flush_acc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // State register
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode; a stalled MEM stage outranks every redirect,
  // including in REFILL, since nothing downstream may advance without dmemReady
  always_comb begin
    w_state_nxt = r_state;
    w_pc_load   = 1'b0;
    w_pc_next   = '0;
    w_en_if     = 1'b1;
    w_en_dec    = 1'b1;
    w_en_exe    = 1'b1;
    w_en_mem    = 1'b1;
    w_bub_dec   = 1'b0;
    w_bub_exe   = 1'b0;
    w_flush_acc = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_pc_load   = 1'b1;
        w_pc_next   = RESET_PC;
        w_bub_dec   = 1'b1;
        w_bub_exe   = 1'b1;
        w_state_nxt = ST_REFILL;
      end
      default: begin
        if (!dmemReady) begin
          w_en_if     = 1'b0;
          w_en_dec    = 1'b0;
          w_en_exe    = 1'b0;
          w_en_mem    = 1'b0;
          w_state_nxt = ST_MEM_WAIT;
        end else if (flushReq) begin
          w_pc_load   = 1'b1;
          w_pc_next   = PCtarget;
          w_bub_dec   = 1'b1;
          w_bub_exe   = 1'b1;
          w_flush_acc = 1'b1;
          w_state_nxt = ST_REFILL;
        end else if ((r_state == ST_REFILL) && !imemReady) begin
          w_en_if     = 1'b0;
          w_bub_dec   = 1'b1;
          w_state_nxt = ST_REFILL;
        end else if (holdReq && ((r_state == ST_RUN) || (r_state == ST_MEM_WAIT))) begin
          // Hold is dropped in LOAD_STALL (same load) and REFILL (DEC is a bubble)
          w_en_if     = 1'b0;
          w_en_dec    = 1'b0;
          w_bub_exe   = 1'b1;
          w_state_nxt = ST_LOAD_STALL;
        end else if (!imemReady) begin
          w_en_if     = 1'b0;
          w_bub_dec   = 1'b1;
          w_state_nxt = ST_RUN;
        end else if (branchReq) begin
          w_pc_load   = 1'b1;
          w_pc_next   = PCtarget;
          w_bub_dec   = 1'b1;
          w_state_nxt = ST_REFILL;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
    endcase
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (perfClear) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_en_if && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_acc && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  // Controls are forced low for as long as reset is held
  assign pcLoad     = nReset & w_pc_load;
  assign pcNext     = nReset ? w_pc_next : 32'h0;
  assign enIF       = nReset & w_en_if;
  assign enDEC      = nReset & w_en_dec;
  assign enEXE      = nReset & w_en_exe;
  assign enMEM      = nReset & w_en_mem;
  assign bubbleDEC  = nReset & w_bub_dec;
  assign bubbleEXE  = nReset & w_bub_exe;
  assign stallCount = r_stall_cnt;
  assign flushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic
// checked every cycle against a rule-level reference model.
module tb_pipeline_ctrl;

  localparam int unsigned CW   = 4;
  localparam logic [31:0] RPC  = 32'h0000_1000;
  localparam int          CMAX = (1 << CW) - 1;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          flushReq = 1'b0;
  logic          branchReq = 1'b0;
  logic          holdReq = 1'b0;
  logic [31:0]   PCtarget = 32'h0;
  logic          imemReady = 1'b1;
  logic          dmemReady = 1'b1;
  logic          perfClear = 1'b0;
  logic          pcLoad;
  logic [31:0]   pcNext;
  logic          enIF, enDEC, enEXE, enMEM;
  logic          bubbleDEC, bubbleEXE;
  logic [CW-1:0] stallCount, flushCount;

  pipeline_ctrl #(.CNT_W(CW), .RESET_PC(RPC)) dut (
    .Clock(Clock), .nReset(nReset), .flushReq(flushReq), .branchReq(branchReq),
    .holdReq(holdReq), .PCtarget(PCtarget), .imemReady(imemReady),
    .dmemReady(dmemReady), .perfClear(perfClear), .pcLoad(pcLoad), .pcNext(pcNext),
    .enIF(enIF), .enDEC(enDEC), .enEXE(enEXE), .enMEM(enMEM),
    .bubbleDEC(bubbleDEC), .bubbleEXE(bubbleEXE),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic          pc_load;
    logic [31:0]   pc_next;
    logic [3:0]    en;     // {IF, DEC, EXE, MEM}
    logic [1:0]    bub;    // {DEC, EXE}
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  typedef enum int {M_BOOT, M_RUN, M_LS, M_REFILL, M_MW} mst_t;
  typedef enum int {A_BOOT, A_FREEZE, A_FLUSH, A_HOLD, A_IFSTALL, A_BRANCH, A_NONE} act_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;
  mst_t m_st = M_BOOT;
  int   m_stall = 0;
  int   m_flush = 0;

  // One clock of stimulus; the model decides which rule fires, then maps it to outputs
  task automatic cycle(input logic rstn, input logic fl, input logic br, input logic ho,
                       input logic [31:0] tgt, input logic im, input logic dm,
                       input logic clr);
    exp_t e;
    act_t a;
    mst_t nx;
    @(posedge Clock);
    #1;
    nReset = rstn; flushReq = fl; branchReq = br; holdReq = ho;
    PCtarget = tgt; imemReady = im; dmemReady = dm; perfClear = clr;
    e = '0;
    if (!rstn) begin
      m_st = M_BOOT; m_stall = 0; m_flush = 0;
    end else begin
      e.stall = CW'(m_stall);
      e.flush = CW'(m_flush);
      if (m_st == M_BOOT)                              a = A_BOOT;
      else if (!dm)                                    a = A_FREEZE;
      else if (fl)                                     a = A_FLUSH;
      else if (m_st == M_REFILL && !im)                a = A_IFSTALL;
      else if (ho && (m_st == M_RUN || m_st == M_MW))  a = A_HOLD;
      else if (!im)                                    a = A_IFSTALL;
      else if (br)                                     a = A_BRANCH;
      else                                             a = A_NONE;
      e.en = 4'b1111;
      nx = M_RUN;
      case (a)
        A_BOOT:    begin e.pc_load = 1; e.pc_next = RPC; e.bub = 2'b11; nx = M_REFILL; end
        A_FREEZE:  begin e.en = 4'b0000; nx = M_MW; end
        A_FLUSH:   begin e.pc_load = 1; e.pc_next = tgt; e.bub = 2'b11; nx = M_REFILL; end
        A_HOLD:    begin e.en = 4'b0011; e.bub = 2'b01; nx = M_LS; end
        A_IFSTALL: begin e.en = 4'b0111; e.bub = 2'b10; nx = (m_st == M_REFILL) ? M_REFILL : M_RUN; end
        A_BRANCH:  begin e.pc_load = 1; e.pc_next = tgt; e.bub = 2'b10; nx = M_REFILL; end
        default:   nx = M_RUN;
      endcase
      if (!e.en[3] && m_stall < CMAX) m_stall++;
      if (a == A_FLUSH && m_flush < CMAX) m_flush++;
      if (clr) begin m_stall = 0; m_flush = 0; end
      m_st = nx;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 32'h0, 1, 1, 0);
  endtask

  // Monitor: compare the DUT outputs once per cycle, mid-period
  initial begin
    forever begin
      @(negedge Clock);
      ncyc++;
      if (exp_q.size() > 0) begin
        exp_t e;
        exp_t g;
        e = exp_q.pop_front();
        g = {pcLoad, pcNext, enIF, enDEC, enEXE, enMEM, bubbleDEC, bubbleEXE,
             stallCount, flushCount};
        if (!e.pc_load) begin
          e.pc_next = '0;
          g.pc_next = '0;
        end
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL outputs cyc=%0d got load=%b pc=%h en=%b bub=%b stall=%0d flush=%0d required load=%b pc=%h en=%b bub=%b stall=%0d flush=%0d",
                   ncyc, g.pc_load, g.pc_next, g.en, g.bub, g.stall, g.flush,
                   e.pc_load, e.pc_next, e.en, e.bub, e.stall, e.flush);
        end
      end
    end
  end

  initial begin
    // Reset, then boot with memories ready
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 32'h0, 1, 1, 0);
    idle(4);
    // Load-use hold held for two cycles: one stall only
    cycle(1, 0, 0, 1, 32'h0, 1, 1, 0);
    cycle(1, 0, 0, 1, 32'h0, 1, 1, 0);
    idle(2);
    // Flush and branch together, then the refill waits three cycles
    cycle(1, 1, 1, 0, 32'h0000_0140, 1, 1, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 32'h0, 0, 1, 0);
    idle(2);
    // Flush deferred behind a four-cycle data-memory wait
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 32'h0000_0200, 1, 0, 0);
    cycle(1, 1, 0, 0, 32'h0000_0200, 1, 1, 0);
    idle(2);
    // Stall counter saturation, then clear
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 32'h0, 0, 1, 0);
    cycle(1, 0, 0, 0, 32'h0, 1, 1, 1);
    idle(2);
    // Reset during MEM_WAIT, then the boot sequence again
    cycle(1, 0, 0, 0, 32'h0, 1, 0, 0);
    cycle(1, 0, 0, 0, 32'h0, 1, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 1, 0, 0);
    cycle(0, 0, 0, 0, 32'h0, 1, 0, 0);
    idle(4);
    // Random traffic, including occasional resets and clears
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom & 32'hFFFF_FFFC), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 5) != 0), ($urandom_range(0, 59) == 0));
    end
    idle(1);
    @(negedge Clock);
    @(negedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
